// File: rtl/pet_prg_loader.sv
// PRG image loader: parses a 2-byte little-endian load address from a byte stream, writes the
// payload through the RAM/ROM DMA port and optionally patches the BASIC end-of-program
// pointers. The CPU is held stopped for the whole transfer.
module pet_prg_loader #(
  parameter bit          ALLOW_ROM   = 1'b0,
  parameter bit          PATCH_PTRS  = 1'b1,
  parameter logic [15:0] BASIC_START = 16'h0401,
  parameter logic [7:0]  PTR_BASE    = 8'h2A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {StIdle, StHdrLo, StHdrHi, StData, StPtr, StFin} state_e;

  state_e      state_q;
  logic [16:0] addr_q;       // bit 16 records a carry past $FFFF and stays set
  logic [15:0] load_addr_q;
  logic        last_q;       // final payload byte accepted, its write cycle is in progress
  logic [2:0]  ptr_idx_q;
  logic        s_ready_q;
  logic [15:0] dma_addr_q;
  logic [7:0]  dma_din_q;
  logic        dma_we_q;
  logic        cpu_hold_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] end_addr_q;

  logic accept;
  logic blocked;
  logic to_ptr;

  // Handshake, write-suppression and pointer-patch qualification
  always_comb begin
    accept  = s_valid & s_ready_q;
    blocked = addr_q[16] | ((ALLOW_ROM == 1'b0) & addr_q[15]);
    to_ptr  = PATCH_PTRS & (load_addr_q == BASIC_START) & ~error_q & ~addr_q[16];
  end

  // Loader FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      load_addr_q <= '0;
      last_q      <= 1'b0;
      ptr_idx_q   <= '0;
      s_ready_q   <= 1'b0;
      dma_addr_q  <= '0;
      dma_din_q   <= '0;
      dma_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      end_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // Restart from any state; hold stays asserted so the CPU never runs in between
        state_q    <= StHdrLo;
        last_q     <= 1'b0;
        ptr_idx_q  <= '0;
        s_ready_q  <= 1'b1;
        dma_we_q   <= 1'b0;
        cpu_hold_q <= 1'b1;
        busy_q     <= 1'b1;
        error_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            s_ready_q <= 1'b0;
          end
          StHdrLo: begin
            if (accept) begin
              addr_q[7:0] <= s_data;
              if (s_last) begin
                error_q    <= 1'b1;
                state_q    <= StFin;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
                busy_q     <= 1'b0;
                s_ready_q  <= 1'b0;
                dma_we_q   <= 1'b0;
              end else begin
                state_q <= StHdrHi;
              end
            end
          end
          StHdrHi: begin
            if (accept) begin
              addr_q      <= {1'b0, s_data, addr_q[7:0]};
              load_addr_q <= {s_data, addr_q[7:0]};
              if (s_last) begin
                error_q    <= 1'b1;
                state_q    <= StFin;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
                busy_q     <= 1'b0;
                s_ready_q  <= 1'b0;
                dma_we_q   <= 1'b0;
              end else begin
                state_q <= StData;
              end
            end
          end
          StData: begin
            if (last_q) begin
              // Write cycle of the final byte ends here
              last_q     <= 1'b0;
              dma_we_q   <= 1'b0;
              end_addr_q <= addr_q[15:0];
              if (addr_q[16]) begin
                error_q <= 1'b1;
              end
              if (to_ptr) begin
                state_q   <= StPtr;
                ptr_idx_q <= '0;
              end else begin
                state_q    <= StFin;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
                busy_q     <= 1'b0;
                s_ready_q  <= 1'b0;
              end
            end else if (dma_we_q) begin
              dma_we_q  <= 1'b0;
              s_ready_q <= 1'b1;
            end else if (accept) begin
              dma_addr_q <= addr_q[15:0];
              dma_din_q  <= s_data;
              dma_we_q   <= ~blocked;
              if (blocked) begin
                error_q <= 1'b1;
              end
              addr_q <= (addr_q + 17'd1) | {addr_q[16], 16'h0000};
              if (s_last) begin
                last_q    <= 1'b1;
                s_ready_q <= 1'b0;
              end else begin
                // A suppressed write has no write cycle, so the next byte may follow at once
                s_ready_q <= blocked;
              end
            end
          end
          StPtr: begin
            if (dma_we_q) begin
              dma_we_q <= 1'b0;
            end else if (ptr_idx_q == 3'd6) begin
              state_q    <= StFin;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
              s_ready_q  <= 1'b0;
            end else begin
              // VARTAB, ARYTAB, STREND all receive end_addr (lo, hi)
              dma_addr_q <= {8'h00, PTR_BASE + {5'b00000, ptr_idx_q}};
              dma_din_q  <= ptr_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
              dma_we_q   <= 1'b1;
              ptr_idx_q  <= ptr_idx_q + 3'd1;
            end
          end
          StFin: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign s_ready  = s_ready_q;
  assign dma_addr = dma_addr_q;
  assign dma_din  = dma_din_q;
  assign dma_we   = dma_we_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign end_addr = end_addr_q;

endmodule

// File: tb/tb_pet_prg_loader.sv
// Scoreboard bench for pet_prg_loader: a file-level reference model predicts DMA writes and the
// completion status; a negedge monitor pops and compares whenever the DUT presents them.
module tb_pet_prg_loader;

  localparam bit          AllowRom   = 1'b0;
  localparam bit          PatchPtrs  = 1'b1;
  localparam logic [15:0] BasicStart = 16'h0401;
  localparam int          PtrBase    = 'h2A;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] end_addr;

  pet_prg_loader #(
    .ALLOW_ROM  (AllowRom),
    .PATCH_PTRS (PatchPtrs),
    .BASIC_START(BasicStart),
    .PTR_BASE   (8'(PtrBase))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .dma_addr(dma_addr),
    .dma_din (dma_din),
    .dma_we  (dma_we),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .end_addr(end_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [23:0] exp_w[$];   // {addr, data}
  logic [17:0] exp_d[$];   // {check_end, error, end_addr}
  int          done_cnt = 0;
  int          done_target = 0;
  int          hold_viol = 0;
  bit          in_load = 1'b0;
  logic        prev_we = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Reference model: whole-file view of what the loader must do
  task automatic model_file(input logic [7:0] f[$]);
    int la, n, a, endv;
    bit err;
    if (f.size() < 3) begin
      exp_d.push_back({1'b0, 1'b1, 16'h0000});
    end else begin
      la  = int'(f[0]) + 256 * int'(f[1]);
      n   = f.size() - 2;
      err = 1'b0;
      for (int i = 0; i < n; i++) begin
        a = la + i;
        if (a > 'hFFFF || (!AllowRom && a >= 'h8000)) err = 1'b1;
        else exp_w.push_back({a[15:0], f[i+2]});
      end
      endv = la + n;
      if (endv > 'hFFFF) err = 1'b1;
      if (PatchPtrs && la == int'(BasicStart) && !err) begin
        for (int k = 0; k < 6; k++) begin
          a = PtrBase + k;
          exp_w.push_back({a[15:0], (k % 2 == 1) ? endv[15:8] : endv[7:0]});
        end
      end
      exp_d.push_back({1'b1, err, endv[15:0]});
    end
    done_target++;
  endtask

  // Monitor: compares DUT writes and completions against the scoreboard
  always @(negedge clk) begin
    logic [23:0] e;
    logic [17:0] d;
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (dma_we) begin
        if (exp_w.size() == 0) begin
          check("unexpected_write", {8'h00, dma_addr, dma_din}, 32'hFFFF_FFFF);
        end else begin
          e = exp_w.pop_front();
          check("dma_write", {8'h00, dma_addr, dma_din}, {8'h00, e});
        end
        check("we_with_hold", {31'b0, cpu_hold}, 32'd1);
        check("we_while_busy", {31'b0, busy}, 32'd1);
        check("we_not_back_to_back", {31'b0, prev_we}, 32'd0);
      end
      prev_we = dma_we;
      if (in_load && !done && !cpu_hold) hold_viol++;
      if (done) begin
        done_cnt++;
        in_load = 1'b0;
        if (exp_d.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = exp_d.pop_front();
          check("done_error", {31'b0, error}, {31'b0, d[16]});
          if (d[17]) check("end_addr", {16'h0, end_addr}, {16'h0, d[15:0]});
        end
        check("fin_hold_busy", {30'b0, cpu_hold, busy}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_load = 1'b1;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit last_final, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      int  n   = 0;
      bit  acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        s_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
        s_data  = b[i];
        s_last  = last_final && (i == b.size() - 1);
        acc     = s_valid && s_ready;
        if (!acc) begin
          n++;
          if (n > 100) begin
            checks++;
            $display("FAIL accept_timeout: byte %0d never accepted, s_ready=%b expected 1",
                     i, s_ready);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
          end
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < done_target && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("done_seen", done_cnt, done_target);
    check("writes_drained", exp_w.size(), 0);
    check("hold_continuous", hold_viol, 0);
  endtask

  task automatic run_file(input logic [7:0] f[$], input bit gaps);
    model_file(f);
    pulse_start();
    send_bytes(f, 1'b1, gaps);
    wait_done();
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] p[$];
    int la, len;

    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {s_ready, dma_we, cpu_hold, busy, done, error, dma_addr, dma_din},
          32'd0);
    check("reset_end_addr", {16'h0, end_addr}, 32'd0);

    // s_valid without start is ignored
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check("idle_ignores_valid", {30'b0, s_ready, busy}, 32'd0);
    s_valid = 1'b0;

    // BASIC load with pointer patch
    f = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_file(f, 1'b1);
    // Non-BASIC load
    f = '{8'h3C, 8'h03, 8'h11, 8'h22};
    run_file(f, 1'b1);
    // Crossing into ROM space with ROM writes blocked
    f = '{8'hFF, 8'h7F, 8'h55, 8'h66};
    run_file(f, 1'b1);
    // Single-byte and header-only files
    f = '{8'h01};
    run_file(f, 1'b1);
    f = '{8'h01, 8'h04};
    run_file(f, 1'b1);
    // Continuous s_valid
    f = '{8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_file(f, 1'b0);
    // Address wrap past $FFFF
    f = '{8'hFF, 8'hFF, 8'h77};
    run_file(f, 1'b0);

    // Reset during DATA after two payload bytes
    exp_w.push_back({16'h1000, 8'h01});
    exp_w.push_back({16'h1001, 8'h02});
    pulse_start();
    p = '{8'h00, 8'h10, 8'h01, 8'h02};
    send_bytes(p, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    in_load = 1'b0;
    #1;
    check("midload_reset_outputs",
          {s_ready, dma_we, cpu_hold, busy, done, error, dma_addr, dma_din}, 32'd0);
    check("midload_reset_end_addr", {16'h0, end_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("after_reset_idle", {30'b0, s_ready, busy}, 32'd0);
    check("reset_writes_drained", exp_w.size(), 0);

    // start mid-DATA restarts header parsing with no hold gap
    exp_w.push_back({16'h033C, 8'h11});
    pulse_start();
    p = '{8'h3C, 8'h03, 8'h11};
    send_bytes(p, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    f = '{8'h3C, 8'h03, 8'h77, 8'h88};
    run_file(f, 1'b1);

    // Randomized files
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(3))
        0:       la = int'(BasicStart);
        1:       la = $urandom_range('h7000, 'h0200);
        2:       la = 'h7FF8 + $urandom_range(7);
        default: la = 'hFFF8 + $urandom_range(7);
      endcase
      f = {};
      if ($urandom_range(9) == 0) begin
        len = $urandom_range(2, 1);
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      end else begin
        f.push_back(la[7:0]);
        f.push_back(la[15:8]);
        len = $urandom_range(8, 1);
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      end
      run_file(f, ($urandom_range(1) == 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pet_prg_loader.md
Name: pet_prg_loader

Overview:
- Sequences the DMA write port of the PET RAM/ROM array to inject a PRG image from a byte stream (menu/OSD download).
- Parses the 2-byte little-endian load address, then writes each payload byte to consecutive addresses.
- Optionally patches the BASIC end-of-program pointers.
- Holds the CPU (drives clk_stop) for the whole transfer so CPU and DMA never race on the shared arrays.

Parameters:
- ALLOW_ROM, 0, 1 = payload writes at addresses >= $8000 are permitted (ROM/option-ROM replacement); 0 = such bytes are discarded and flagged.
- PATCH_PTRS, 1, 1 = after a BASIC load, write end address to VARTAB/ARYTAB/STREND.
- BASIC_START, 16'h0401, load address that qualifies a file as a BASIC program.
- PTR_BASE, 8'h2A, zero-page address of VARTAB low byte; ARYTAB = +2, STREND = +4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load, aborting any load in progress.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle when s_valid & s_ready.
- s_last  in  1  qualifies the final byte of the file (sampled with valid & ready).
- dma_addr  out  16  DMA address to RAM/ROM.
- dma_din  out  8  DMA write data.
- dma_we  out  1  DMA write strobe, one clk wide.
- cpu_hold  out  1  CPU clock stop request.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at completion (success or error).
- error  out  1  sticky until next start: short file, address overflow or blocked ROM write.
- end_addr  out  16  first address after the last payload byte; valid when done.

Behaviour:
- Reset (async): state IDLE; s_ready=0, dma_addr=0, dma_din=0, dma_we=0, cpu_hold=0, busy=0, done=0, error=0, end_addr=0.
- Reset mid-load: everything returns to reset values immediately; partial data stays in RAM; no pointer writes occur.
- All outputs are registered.
- States:
  - IDLE: s_ready=0. On start -> HDR_LO; cpu_hold=1, busy=1, error=0.
  - HDR_LO: s_ready=1. On accept, latch addr[7:0] -> HDR_HI. If s_last: error=1 -> FIN.
  - HDR_HI: s_ready=1. On accept, latch addr[15:8] -> DATA. If s_last: error=1 -> FIN (header-only file is an error).
  - DATA: s_ready = ~dma_we, so throughput is at most 1 byte per 2 clk.
    - On accept: dma_addr=addr, dma_din=s_data, dma_we=1 next cycle, then addr+=1.
    - Blocked case: if ALLOW_ROM=0 and addr[15]=1, or 17-bit addr counter has carried past $FFFF, suppress dma_we, set error=1, still consume the byte.
    - On accepted s_last, once its write cycle completes: end_addr=addr after increment (16-bit; $FFFF+1 gives $0000 with error=1).
    - Then -> PTR if PATCH_PTRS=1 & load addr == BASIC_START & error=0; else -> FIN.
  - PTR: six back-to-back writes, each one cycle with dma_we=1 and 1-cycle gaps. Addresses PTR_BASE+0..5, data lo,hi,lo,hi,lo,hi of end_addr. Then -> FIN.
  - FIN: one cycle; done=1, cpu_hold=0, busy=0 -> IDLE.
- start in any non-IDLE state: abort any current write (dma_we=0 next cycle), clear error, -> HDR_LO; cpu_hold remains 1 without a gap.
- start coincident with reset: reset wins.
- s_valid without a preceding start is ignored (s_ready=0).
- dma_we is never asserted in IDLE or FIN.
- dma_we is never asserted while cpu_hold=0.

Test Plan:
- start; stream 01 04 AA BB CC (last on CC), PATCH_PTRS=1:
  - writes $0401=AA, $0402=BB, $0403=CC.
  - then $2A=04,$2B=04,$2C=04,$2D=04,$2E=04,$2F=04 (end_addr=$0404).
  - done pulse, error=0, cpu_hold high from start until the FIN cycle.
- Load at $033C with bytes 11 22: writes only $033C/$033D, no pointer writes, end_addr=$033E.
- ALLOW_ROM=0, load at $7FFF with bytes 55 66: $7FFF=55 written, $8000 not written, error=1, no pointer writes.
- Stream single byte 01 with s_last: no dma_we, error=1, done pulse.
- Assert reset during DATA after 2 bytes: all outputs 0 immediately; after release, IDLE and s_ready=0.
- start pulsed mid-DATA: next two bytes are treated as new header; cpu_hold stays high continuously.
- s_valid held high continuously: s_ready toggles; exactly one dma_we per payload byte, never two consecutive cycles.
